// File: rtl/watermark_blend_pipe.sv
// Three-stage rounded alpha blend: out = (host*(2^A - alpha) + wm*alpha + 2^(A-1)) >> A,
// with per-frame alpha locking and output-side raster markers for the frame writer.
module watermark_blend_pipe #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned ALPHA_W = 8,
  parameter int unsigned IMG_W   = 256,
  parameter int unsigned IMG_H   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALPHA_W-1:0] alpha,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   host_pix,
  input  logic [PIX_W-1:0]   wm_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pix,
  output logic               out_sol,
  output logic               out_eol,
  output logic               out_eof,
  output logic               frame_done
);

  localparam int unsigned PW = PIX_W + ALPHA_W + 1;
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [PW-1:0] UNITY = PW'(1) << ALPHA_W;
  localparam logic [PW-1:0] ROUND = PW'(1) << (ALPHA_W - 1);
  localparam logic [PW-1:0] PMAX  = {{(PW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic               en, in_fire, out_fire, first_px;
  logic [ALPHA_W-1:0] alpha_q, a_eff;
  logic [CW-1:0]      in_col_q, in_col_d, col_q, col_d;
  logic [RW-1:0]      in_row_q, in_row_d, row_q, row_d;

  logic               s1_valid_q, s2_valid_q, s3_valid_q;
  logic [PIX_W-1:0]   s1_host_q, s1_wm_q, s3_pix_q, pix_d;
  logic [ALPHA_W-1:0] s1_alpha_q;
  logic [PW-1:0]      s2_ph_q, s2_pw_q, sum, shr;
  logic               frame_done_q;

  always_comb begin
    en       = ~s3_valid_q | out_ready;
    in_fire  = in_valid & en;
    out_fire = s3_valid_q & out_ready;
    first_px = (in_col_q == '0) && (in_row_q == '0);
    // Pixel 0 of a frame carries the live alpha; every later pixel reuses the locked copy.
    a_eff    = first_px ? alpha : alpha_q;

    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (in_fire) begin
      if (in_col_q == CW'(IMG_W - 1)) begin
        in_col_d = '0;
        in_row_d = (in_row_q == RW'(IMG_H - 1)) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end

    col_d = col_q;
    row_d = row_q;
    if (out_fire) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    sum   = s2_ph_q + s2_pw_q + ROUND;
    shr   = sum >> ALPHA_W;
    pix_d = (shr > PMAX) ? '1 : shr[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alpha_q      <= '0;
      in_col_q     <= '0;
      in_row_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_host_q    <= '0;
      s1_wm_q      <= '0;
      s1_alpha_q   <= '0;
      s2_valid_q   <= 1'b0;
      s2_ph_q      <= '0;
      s2_pw_q      <= '0;
      s3_valid_q   <= 1'b0;
      s3_pix_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= out_fire & out_eof;
      if (in_fire && first_px) alpha_q <= alpha;
      if (en) begin
        s1_valid_q <= in_valid;
        s1_host_q  <= host_pix;
        s1_wm_q    <= wm_pix;
        s1_alpha_q <= a_eff;
        s2_valid_q <= s1_valid_q;
        s2_ph_q    <= PW'(s1_host_q) * (UNITY - PW'(s1_alpha_q));
        s2_pw_q    <= PW'(s1_wm_q) * PW'(s1_alpha_q);
        s3_valid_q <= s2_valid_q;
        s3_pix_q   <= pix_d;
      end
    end
  end

  assign in_ready   = en;
  assign out_valid  = s3_valid_q;
  assign out_pix    = s3_pix_q;
  assign out_sol    = s3_valid_q & (col_q == '0);
  assign out_eol    = s3_valid_q & (col_q == CW'(IMG_W - 1));
  assign out_eof    = out_eol & (row_q == RW'(IMG_H - 1));
  assign frame_done = frame_done_q;

endmodule
